// File: rtl/icache_dm.sv
// Direct-mapped instruction cache with sequential line refill and whole-cache flush.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_dm #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned NUM_LINES      = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] addr_in,
    output logic [DATA_W-1:0] data_out,
    output logic              resp_valid,
    output logic              stall,
    input  logic              flush,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dataOut,
    input  logic              mem_valid,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);

    localparam int unsigned OFFB  = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDXB  = $clog2(NUM_LINES);
    localparam int unsigned TAGB  = ADDR_W - 2 - OFFB - IDXB;
    localparam int unsigned LINEW = TAGB + IDXB;
    localparam logic [OFFB-1:0] LastWord = OFFB'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {StIdle, StRefill, StRespond} state_e;

    state_e              r_state;
    state_e              w_state_next;
    logic [NUM_LINES-1:0] r_valid;
    logic [TAGB-1:0]     r_tag [NUM_LINES];
    logic [DATA_W-1:0]   r_mem [NUM_LINES*WORDS_PER_LINE];
    logic [LINEW-1:0]    r_line_addr;
    logic [OFFB-1:0]     r_req_off;
    logic [OFFB-1:0]     r_cnt;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_resp_valid;
    logic                r_flush_pend;

    logic [OFFB-1:0]     w_off;
    logic [IDXB-1:0]     w_idx;
    logic [TAGB-1:0]     w_tag;
    logic [IDXB-1:0]     w_ridx;
    logic [TAGB-1:0]     w_rtag;
    logic                w_flush_now;
    logic                w_accept;
    logic                w_hit;
    logic                w_miss;
    logic                w_fill;
    logic                w_last;
    logic                w_unused_addr;

    assign w_off         = addr_in[OFFB+1:2];
    assign w_idx         = addr_in[OFFB+IDXB+1:OFFB+2];
    assign w_tag         = addr_in[ADDR_W-1:OFFB+IDXB+2];
    assign w_unused_addr = ^addr_in[1:0];
    assign w_ridx        = r_line_addr[IDXB-1:0];
    assign w_rtag        = r_line_addr[LINEW-1:IDXB];

    // A pending flush takes the first IDLE cycle, so no request is accepted then.
    assign w_flush_now = (r_state == StIdle) && (flush || r_flush_pend);
    assign w_accept    = (r_state == StIdle) && req_valid && !w_flush_now;
    assign w_hit       = w_accept && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss      = w_accept && !w_hit;
    assign w_fill      = (r_state == StRefill) && mem_valid;
    assign w_last      = (r_cnt == LastWord);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall        = 1'b0;
        unique case (r_state)
            StIdle: begin
                stall = w_flush_now;
                if (w_miss) w_state_next = StRefill;
            end
            StRefill: begin
                stall = 1'b1;
                if (w_fill && w_last) w_state_next = StRespond;
            end
            StRespond: begin
                stall        = 1'b1;
                w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_valid      <= '0;
            r_line_addr  <= '0;
            r_req_off    <= '0;
            r_cnt        <= '0;
            r_data_out   <= '0;
            r_resp_valid <= 1'b0;
            r_flush_pend <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_flush_now) begin
                r_valid      <= '0;
                r_flush_pend <= 1'b0;
            end else if ((r_state != StIdle) && flush) begin
                r_flush_pend <= 1'b1;
            end
            if (w_hit) begin
                r_data_out   <= r_mem[{w_idx, w_off}];
                r_resp_valid <= 1'b1;
            end
            // Invalidate up front so an aborted refill never leaves a stale-tag line valid.
            if (w_miss) begin
                r_line_addr    <= addr_in[ADDR_W-1:OFFB+2];
                r_req_off      <= w_off;
                r_cnt          <= '0;
                r_valid[w_idx] <= 1'b0;
            end
            if (w_fill) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_valid[w_ridx] <= 1'b1;
                    r_resp_valid    <= 1'b1;
                    r_data_out      <= (r_req_off == LastWord) ? mem_dataOut
                                                               : r_mem[{w_ridx, r_req_off}];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_mem[{w_ridx, r_cnt}] <= mem_dataOut;
            if (w_last) r_tag[w_ridx] <= w_rtag;
        end
    end

    assign data_out   = r_data_out;
    assign resp_valid = r_resp_valid;
    assign mem_req    = (r_state == StRefill);
    assign mem_addr   = {r_line_addr, r_cnt, 2'b00};

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_flush_now) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit)  r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Self-checking bench for icache_dm: randomized requests against a line-level cache model
// and a latency-programmable memory responder.
module tb_icache_dm;

    localparam int NL  = 16;
    localparam int WPL = 4;

    logic        clock = 1'b0;
    logic        reset, req_valid, flush, mem_valid;
    logic [31:0] addr_in, mem_dataOut, mem_addr, data_out, hit_count, miss_count;
    logic        resp_valid, stall, mem_req;

    icache_dm dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .addr_in(addr_in),
        .data_out(data_out), .resp_valid(resp_valid), .stall(stall), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_dataOut(mem_dataOut),
        .mem_valid(mem_valid), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int lat = 1;
    bit spurious = 0;
    logic [31:0] mem_log[$];
    int stab_err = 0;
    int proto_err = 0;
    int wait_cnt = 0;
    bit last_req = 0;
    logic [31:0] last_addr = '0;

    bit          m_valid[NL];
    int unsigned m_tag[NL];
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h40 && a <= 32'h4C) return 32'hA0 + (a - 32'h40) / 4;
        return a ^ 32'h5EED_0000 ^ (a << 9);
    endfunction

    // Model: a line holds whole-line tags; memory contents are fixed, so data is mem_word().
    function automatic bit model_access(input logic [31:0] a);
        int unsigned idx = (a / (WPL * 4)) % NL;
        int unsigned tag = a / (WPL * 4 * NL);
        bit hit = m_valid[idx] && (m_tag[idx] == tag);
        if (hit) m_hits++;
        else begin
            m_misses++;
            m_valid[idx] = 1;
            m_tag[idx]   = tag;
        end
        return hit;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < NL; i++) m_valid[i] = 0;
        m_hits   = 0;
        m_misses = 0;
    endfunction

    // Memory responder: answers each requested word after 'lat' waiting cycles.
    initial begin
        mem_valid   = 1'b0;
        mem_dataOut = '0;
        forever begin
            @(negedge clock);
            mem_valid = 1'b0;
            if (reset) begin
                wait_cnt = 0;
                last_req = 0;
            end else if (mem_req) begin
                if (!stall) proto_err++;
                if (last_req && wait_cnt > 0 && mem_addr !== last_addr) stab_err++;
                if (wait_cnt >= lat) begin
                    mem_valid   = 1'b1;
                    mem_dataOut = mem_word(mem_addr);
                    mem_log.push_back(mem_addr);
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
                last_addr = mem_addr;
                last_req  = 1;
            end else begin
                wait_cnt = 0;
                last_req = 0;
                if (spurious) begin
                    mem_valid   = 1'b1;
                    mem_dataOut = 32'hBAD0_BAD0;
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] a, input int flush_at, output int n_resp,
                          output logic [31:0] rdata, output int resp_cyc);
        int k;
        n_resp   = 0;
        rdata    = '0;
        resp_cyc = -1;
        @(negedge clock);
        k = 0;
        while (stall && k < 50) begin
            @(negedge clock);
            k++;
        end
        mem_log.delete();
        req_valid = 1'b1;
        addr_in   = a;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        addr_in   = $urandom;
        for (int i = 0; i < 500; i++) begin
            flush = (i == flush_at);
            if (resp_valid) begin
                n_resp++;
                rdata = data_out;
                if (resp_cyc < 0) resp_cyc = i;
            end
            if (resp_cyc >= 0 && i >= resp_cyc + 2) break;
            @(posedge clock);
            #1;
        end
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; flush = 1'b0; addr_in = '0;
        repeat (3) @(posedge clock);
        #1;
        n_checks++; if (data_out !== 32'h0) begin n_errors++; $display("FAIL reset_data_out got=%h want=0", data_out); end
        n_checks++; if (resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid got=%b want=0", resp_valid); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got=%b want=0", stall); end
        n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        n_checks++; if (mem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_errors++; $display("FAIL reset_counters got=%0d/%0d want=0/0", hit_count, miss_count); end
        @(negedge clock);
        reset = 1'b0;
        flush = 1'b1;
        #1;
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL idle_flush_stall got=%b want=1", stall); end
        @(negedge clock);
        flush = 1'b0;
        model_flush();
    endtask

    task automatic test_miss_refill();
        int nr, rc;
        logic [31:0] rd;
        bit eh;
        lat = 1;
        eh = model_access(32'h40);
        do_req(32'h40, -1, nr, rd, rc);
        n_checks++; if (nr != 1) begin n_errors++; $display("FAIL miss_resp_count got=%0d want=1", nr); end
        n_checks++; if (rd !== 32'hA0) begin n_errors++; $display("FAIL miss_data got=%h want=a0", rd); end
        n_checks++; if (eh || rc <= 0) begin n_errors++; $display("FAIL miss_latency got=%0d want>0", rc); end
        n_checks++; if (mem_log.size() != WPL) begin n_errors++; $display("FAIL miss_words got=%0d want=%0d", mem_log.size(), WPL); end
        for (int k = 0; k < mem_log.size(); k++) begin
            n_checks++; if (mem_log[k] !== 32'h40 + 32'(4 * k)) begin n_errors++; $display("FAIL miss_mem_addr[%0d] got=%h want=%h", k, mem_log[k], 32'h40 + 32'(4 * k)); end
        end
    endtask

    task automatic test_hit();
        int nr, rc;
        logic [31:0] rd;
        bit eh;
        eh = model_access(32'h48);
        do_req(32'h48, -1, nr, rd, rc);
        n_checks++; if (!eh || rc != 0 || nr != 1) begin n_errors++; $display("FAIL hit_latency got=%0d/%0d want=0/1", rc, nr); end
        n_checks++; if (rd !== 32'hA2) begin n_errors++; $display("FAIL hit_data got=%h want=a2", rd); end
        n_checks++; if (mem_log.size() != 0) begin n_errors++; $display("FAIL hit_mem_req got=%0d words want=0", mem_log.size()); end
        n_checks++; if (data_out !== 32'hA2 || resp_valid !== 1'b0) begin n_errors++; $display("FAIL hit_hold got=%h/%b want=a2/0", data_out, resp_valid); end
`ifdef ICACHE_STATS_EN
        n_checks++; if (hit_count !== m_hits || miss_count !== m_misses) begin n_errors++; $display("FAIL hit_stats got=%0d/%0d want=%0d/%0d", hit_count, miss_count, m_hits, m_misses); end
`else
        n_checks++; if (hit_count !== 32'h0 || miss_count !== 32'h0) begin n_errors++; $display("FAIL hit_stats got=%0d/%0d want=0/0", hit_count, miss_count); end
`endif
    endtask

    task automatic test_conflict();
        int nr, rc;
        logic [31:0] rd;
        bit eh;
        eh = model_access(32'h440);
        do_req(32'h440, -1, nr, rd, rc);
        n_checks++; if (eh || mem_log.size() != WPL || mem_log[0] !== 32'h440) begin n_errors++; $display("FAIL conflict_refill got=%0d words want=%0d from 440", mem_log.size(), WPL); end
        n_checks++; if (rd !== mem_word(32'h440) || nr != 1) begin n_errors++; $display("FAIL conflict_data got=%h want=%h", rd, mem_word(32'h440)); end
        eh = model_access(32'h40);
        do_req(32'h40, -1, nr, rd, rc);
        n_checks++; if (eh || mem_log.size() != WPL) begin n_errors++; $display("FAIL conflict_evict got=%0d words want=%0d", mem_log.size(), WPL); end
        n_checks++; if (rd !== 32'hA0) begin n_errors++; $display("FAIL conflict_redata got=%h want=a0", rd); end
    endtask

    task automatic test_flush();
        int nr, rc;
        logic [31:0] rd;
        bit eh;
        @(negedge clock);
        flush = 1'b1; req_valid = 1'b1; addr_in = 32'h40;
        @(posedge clock);
        #1;
        flush = 1'b0; req_valid = 1'b0;
        n_checks++; if (resp_valid !== 1'b0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL flush_blocks_req got=%b/%b want=0/0", resp_valid, mem_req); end
        model_flush();
        eh = model_access(32'h40);
        do_req(32'h40, -1, nr, rd, rc);
        n_checks++; if (eh || mem_log.size() != WPL) begin n_errors++; $display("FAIL flush_invalidates got=%0d words want=%0d", mem_log.size(), WPL); end
        eh = model_access(32'h80);
        do_req(32'h80, 3, nr, rd, rc);
        model_flush();
        n_checks++; if (nr != 1 || rd !== mem_word(32'h80) || mem_log.size() != WPL) begin n_errors++; $display("FAIL flush_mid_refill got=%0d/%h/%0d want=1/%h/%0d", nr, rd, mem_log.size(), mem_word(32'h80), WPL); end
        eh = model_access(32'h80);
        do_req(32'h80, -1, nr, rd, rc);
        n_checks++; if (eh || mem_log.size() != WPL || rd !== mem_word(32'h80)) begin n_errors++; $display("FAIL flush_pending_applied got=%0d words want=%0d", mem_log.size(), WPL); end
`ifdef ICACHE_STATS_EN
        n_checks++; if (hit_count !== m_hits || miss_count !== m_misses) begin n_errors++; $display("FAIL flush_stats got=%0d/%0d want=%0d/%0d", hit_count, miss_count, m_hits, m_misses); end
`endif
    endtask

    task automatic test_slow_mem();
        int nr, rc, se;
        logic [31:0] rd;
        bit eh;
        lat = 5;
        se = stab_err;
        eh = model_access(32'hC4);
        do_req(32'hC4, -1, nr, rd, rc);
        n_checks++; if (stab_err != se) begin n_errors++; $display("FAIL slow_addr_stable got=%0d changes want=0", stab_err - se); end
        n_checks++; if (eh || nr != 1 || rd !== mem_word(32'hC4)) begin n_errors++; $display("FAIL slow_resp got=%0d/%h want=1/%h", nr, rd, mem_word(32'hC4)); end
        n_checks++; if (rc < 4 * 6) begin n_errors++; $display("FAIL slow_latency got=%0d want>=24", rc); end
        lat = 1;
    endtask

    task automatic test_reset_mid_refill();
        int nr, rc, k;
        logic [31:0] rd;
        bit eh;
        lat = 5;
        @(negedge clock);
        mem_log.delete();
        req_valid = 1'b1; addr_in = 32'h100;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        k = 0;
        while (mem_log.size() < 2 && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        @(posedge clock);
        #1;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin n_errors++; $display("FAIL rst_mid_word2 got=%b/%h want=1/108", mem_req, mem_addr); end
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (mem_req !== 1'b0 || resp_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_drop got=%b/%b want=0/0", mem_req, resp_valid); end
        @(negedge clock);
        reset = 1'b0;
        model_flush();
        eh = model_access(32'h100);
        do_req(32'h100, -1, nr, rd, rc);
        n_checks++; if (eh || mem_log.size() != WPL || mem_log[0] !== 32'h100) begin n_errors++; $display("FAIL rst_mid_refetch got=%0d words want=%0d from 100", mem_log.size(), WPL); end
        n_checks++; if (nr != 1 || rd !== mem_word(32'h100)) begin n_errors++; $display("FAIL rst_mid_data got=%h want=%h", rd, mem_word(32'h100)); end
        lat = 1;
    endtask

    task automatic test_random();
        int nr, rc, fa;
        logic [31:0] rd, a;
        bit eh;
        spurious = 1;
        for (int n = 0; n < 80; n++) begin
            a = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 15)) << 4) |
                (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            lat = $urandom_range(0, 2);
            fa  = ($urandom_range(0, 9) == 0) ? 1 : -1;
            eh  = model_access(a);
            do_req(a, fa, nr, rd, rc);
            if (fa >= 0) model_flush();
            n_checks++; if (nr != 1 || rd !== mem_word(a & ~32'h3)) begin n_errors++; $display("FAIL rand_data a=%h got=%0d/%h want=1/%h", a, nr, rd, mem_word(a & ~32'h3)); end
            n_checks++; if (mem_log.size() != (eh ? 0 : WPL) || (eh && rc != 0)) begin n_errors++; $display("FAIL rand_hitmiss a=%h got=%0d words want=%0d", a, mem_log.size(), eh ? 0 : WPL); end
            if (!eh && mem_log.size() == WPL) begin
                n_checks++; if (mem_log[WPL-1] !== ((a & ~32'hF) | 32'hC)) begin n_errors++; $display("FAIL rand_last_addr got=%h want=%h", mem_log[WPL-1], (a & ~32'hF) | 32'hC); end
            end
        end
        spurious = 0;
        lat = 1;
`ifdef ICACHE_STATS_EN
        n_checks++; if (hit_count !== m_hits || miss_count !== m_misses) begin n_errors++; $display("FAIL rand_stats got=%0d/%0d want=%0d/%0d", hit_count, miss_count, m_hits, m_misses); end
`endif
        n_checks++; if (proto_err != 0 || stab_err != 0) begin n_errors++; $display("FAIL protocol got=%0d/%0d want=0/0", proto_err, stab_err); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_miss_refill();
        test_hit();
        test_conflict();
        test_flush();
        test_slow_mem();
        test_reset_mid_refill();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised direct-mapped instruction cache between the fetch stage and instruction memory.
- Successor to the pass-through fetch buffer: it holds NUM_LINES lines of WORDS_PER_LINE words each.
- Hits return in one cycle. Misses run a sequential line refill from memory using a valid handshake, and fetch is stalled meanwhile.
- Supports a whole-cache flush for fence.i / self-modifying code.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, instruction word width; fixed at 32 (word = 4 bytes).
- NUM_LINES, 16, number of lines; power of two, at least 2.
- WORDS_PER_LINE, 4, words per line; power of two, at least 2.

Ports:
- clock, in, 1, rising-edge clock.
- reset, in, 1, asynchronous active-high reset.
- req_valid, in, 1, fetch presents addr_in this cycle.
- addr_in, in, ADDR_W, byte fetch address; bits [1:0] ignored.
- data_out, out, DATA_W, instruction for the accepted request.
- resp_valid, out, 1, data_out valid this cycle.
- stall, out, 1, cache cannot accept a request this cycle.
- flush, in, 1, invalidate all lines.
- mem_req, out, 1, memory word read request.
- mem_addr, out, ADDR_W, word-aligned memory byte address.
- mem_dataOut, in, DATA_W, memory read data.
- mem_valid, in, 1, mem_dataOut valid for the current mem_addr.
- hit_count, out, 32, statistics counter (see Optional Feature).
- miss_count, out, 32, statistics counter (see Optional Feature).

Behaviour:
- Address split:
  - offset = addr_in[OFFB+1:2], where OFFB = log2(WORDS_PER_LINE).
  - index = next log2(NUM_LINES) bits.
  - tag = remaining upper bits.
- Storage: per-line valid bit, tag, and data words.
- Reset values (asynchronous):
  - all valid bits cleared; FSM to IDLE.
  - data_out = 0; resp_valid = 0; stall = 0.
  - mem_req = 0; mem_addr = 0.
  - counters = 0; pending flush cleared.
- FSM state IDLE:
  - stall = 0, except stall = 1 in any cycle where flush = 1.
  - flush = 1: clear all valid bits at the next edge; a req_valid in the same cycle is not accepted.
  - req_valid = 1 with a hit (valid and tag match): next cycle data_out = word, resp_valid = 1.
  - req_valid = 1 with a miss: latch addr_in, go to REFILL; resp_valid = 0 next cycle.
- FSM state REFILL:
  - stall = 1; requests are ignored.
  - Word counter starts at 0. mem_req = 1 and mem_addr = {tag, index, counter, 2'b00}.
  - mem_req and mem_addr are held stable until mem_valid = 1.
  - On each mem_valid: write mem_dataOut into the line at the counter position, then increment the counter.
  - On mem_valid for the last word (counter = WORDS_PER_LINE-1):
    - set the line's valid bit and tag; drop mem_req.
    - next cycle: data_out = requested word (forwarded from mem_dataOut if it was the last word), resp_valid = 1.
    - go to RESPOND.
  - mem_valid while mem_req = 0 is ignored.
- FSM state RESPOND:
  - One cycle, stall = 1, then to IDLE.
  - resp_valid is high exactly one cycle per accepted request.
- Flush during REFILL or RESPOND: latched as pending. The refill completes and its response is delivered; the pending flush is then applied in the first IDLE cycle, with stall = 1 in that cycle.
- A miss replaces the line unconditionally; no write port, no dirty state.
- Address wrap: the refill counter wraps only within its line; mem_addr never crosses a line boundary.
- resp_valid and data_out hold their last value only through the cycle they are asserted. resp_valid returns to 0 otherwise; data_out keeps its last value.
- Reset mid-refill: mem_req drops immediately; the partially filled line stays invalid.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - hit_count increments on each accepted hit; miss_count on each accepted miss.
  - 32-bit wrap-around counters, cleared by reset and by flush.
- Undefined: hit_count and miss_count are tied to 0; no counter flops are built.

Test Plan:
- Reset, then req 0x0000_0040 with mem returning 0xA0..0xA3 for words 0x40..0x4C (1-cycle mem_valid latency) -> mem_addr sequence 0x40, 0x44, 0x48, 0x4C; stall high; one resp_valid with data_out = 0xA0.
- After the above, req 0x0000_0048 -> hit, data_out = 0xA2 next cycle, mem_req stays 0; with ICACHE_STATS_EN: hit = 1, miss = 1.
- Req 0x0000_0440 (same index as 0x40, different tag) -> miss, refill from 0x440; a following req 0x40 misses again.
- Flush asserted mid-refill of 0x80 -> refill completes and responds; then valid bits clear; re-request 0x80 -> miss.
- mem_valid delayed 5 cycles per word -> mem_addr stable during each wait; no spurious resp_valid.
- Reset asserted while refilling word 2 -> mem_req = 0 immediately, resp_valid = 0; re-request of the same address -> full refill from word 0.
